// File: rtl/ysyx_22041207_rx_responder_pkg.sv
// Shared definitions for the rx read-channel responder and its helpers.
package ysyx_22041207_rx_responder_pkg;

    // Responder control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MEM  = 2'd2,
        ST_RESP = 2'd3
    } rx_state_e;

    // Byte-lane masks for the common access sizes
    localparam logic [7:0] SIZE_BYTE  = 8'h01;
    localparam logic [7:0] SIZE_HALF  = 8'h03;
    localparam logic [7:0] SIZE_WORD  = 8'h0F;
    localparam logic [7:0] SIZE_DWORD = 8'hFF;

    // Default legal memory window
    localparam logic [63:0] DEFAULT_MEM_BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DEFAULT_MEM_BYTES = 64'h0000_0000_0800_0000;

endpackage

// File: rtl/ysyx_22041207_rx_responder_align.sv
// Byte alignment of a fetched doubleword: shift the addressed byte down to
// lane 0, zero-fill above, then clear every lane not selected by the size mask.
module ysyx_22041207_rx_align (
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [7:0]  size,
    output logic [63:0] data
);

    logic [63:0] shifted;

    // Logical shift brings in zeros, so bytes past the doubleword read as 0
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = 64'h0;
        for (int k = 0; k < 8; k++) begin
            data[8*k +: 8] = size[k] ? shifted[8*k +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/ysyx_22041207_rx_responder.sv
// Memory-side responder for the fetch read channel. One read in flight:
// address handshake, optional idle wait, req/ack doubleword fetch, then the
// aligned and masked result is held until the initiator takes it.
//
// Handshakes: a transfer happens on a rising clk edge where the channel's
// valid and ready are both high. rx_r_ready_o is registered and only high in
// IDLE (low on the first IDLE cycle after a response); rx_data_valid, with
// rx_data_read_o and rx_resp_err, stays stable until rx_data_ready is seen.
// mem_req is held with a stable mem_addr until mem_ack.
module ysyx_22041207_rx_responder
    import ysyx_22041207_rx_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [63:0] MEM_BASE    = DEFAULT_MEM_BASE,
    parameter logic [63:0] MEM_BYTES   = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_r_valid_i,
    output logic        rx_r_ready_o,
    input  logic [63:0] rx_r_addr_i,
    input  logic [7:0]  rx_r_size_i,
    output logic [63:0] rx_data_read_o,
    output logic        rx_data_valid,
    input  logic        rx_data_ready,
    output logic        rx_resp_err,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam logic [63:0] MEM_LIMIT = MEM_BASE + MEM_BYTES;
    localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_CYCLES);

    rx_state_e   state;
    logic [63:0] addr_q;
    logic [7:0]  size_q;
    logic [7:0]  wait_cnt;
    logic [63:0] aligned;
    logic        req_fire;
    logic        addr_hit;

    assign req_fire = (state == ST_IDLE) && rx_r_valid_i && rx_r_ready_o;
    assign addr_hit = (rx_r_addr_i >= MEM_BASE) && (rx_r_addr_i < MEM_LIMIT);

    ysyx_22041207_rx_align u_align (
        .rdata  (mem_rdata),
        .offset (addr_q[2:0]),
        .size   (size_q),
        .data   (aligned)
    );

    // Control FSM with all channel outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rx_r_ready_o   <= 1'b0;
            rx_data_valid  <= 1'b0;
            rx_resp_err    <= 1'b0;
            rx_data_read_o <= 64'h0;
            mem_req        <= 1'b0;
            mem_addr       <= 64'h0;
            addr_q         <= 64'h0;
            size_q         <= 8'h0;
            wait_cnt       <= 8'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        addr_q       <= rx_r_addr_i;
                        size_q       <= rx_r_size_i;
                        rx_r_ready_o <= 1'b0;
                        if (!addr_hit) begin
                            // Out of window: answer at once, never touch memory
                            rx_data_read_o <= 64'h0;
                            rx_resp_err    <= 1'b1;
                            rx_data_valid  <= 1'b1;
                            state          <= ST_RESP;
                        end else if (WAIT_CYCLES > 0) begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= ST_WAIT;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {rx_r_addr_i[63:3], 3'b000};
                            state    <= ST_MEM;
                        end
                    end else begin
                        rx_r_ready_o <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Spend exactly WAIT_CYCLES cycles here before requesting
                    if (wait_cnt <= 8'd1) begin
                        wait_cnt <= 8'h0;
                        mem_req  <= 1'b1;
                        mem_addr <= {addr_q[63:3], 3'b000};
                        state    <= ST_MEM;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        rx_data_read_o <= aligned;
                        rx_resp_err    <= 1'b0;
                        rx_data_valid  <= 1'b1;
                        mem_req        <= 1'b0;
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rx_data_ready) begin
                        rx_data_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
